freq_meter: RTL and testbench

- Downstream consumer of the programmable frequency divider output.
- Counts rising edges of a single-bit input `sig_in` over a programmable gate window of `clk` cycles.
- Measures the period of `sig_in` in `clk` cycles between consecutive rising edges.
- Used to self-check each divider select setting in system and in test.

---
 rtl/freq_meter.sv | 160 ++++++++++++++++
 tb/tb_freq_meter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of sig_in over a gate window of clk cycles and
// reports the last edge-to-edge period. Define FREQ_METER_SYNC_EN to add a 2-flop input synchroniser.
module freq_meter #(
    parameter int GATE_W = 16,
    parameter int CNT_W  = 16,
    parameter int PER_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              sig_in,
    output logic              busy,
    output logic              valid,
    output logic [CNT_W-1:0]  edge_cnt,
    output logic [PER_W-1:0]  period,
    output logic              cnt_ovf,
    output logic              per_ovf
);

    typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

    state_t            state_q, state_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [PER_W-1:0]  per_run_q, per_run_d;
    logic [PER_W-1:0]  per_last_q, per_last_d;
    logic              seen_q, seen_d;
    logic              cnt_ovf_acc_q, cnt_ovf_acc_d;
    logic              per_ovf_acc_q, per_ovf_acc_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [PER_W-1:0]  period_q, period_d;
    logic              cnt_ovf_q, cnt_ovf_d;
    logic              per_ovf_q, per_ovf_d;
    logic              sig_s, sig_d_q, rise;

`ifdef FREQ_METER_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
        end
    end

    assign sig_s = sync2_q;
`else
    assign sig_s = sig_in;
`endif

    assign rise = sig_s & ~sig_d_q;

    always_comb begin
        state_d       = state_q;
        gate_d        = gate_q;
        acc_d         = acc_q;
        per_run_d     = per_run_q;
        per_last_d    = per_last_q;
        seen_d        = seen_q;
        cnt_ovf_acc_d = cnt_ovf_acc_q;
        per_ovf_acc_d = per_ovf_acc_q;
        edge_cnt_d    = edge_cnt_q;
        period_d      = period_q;
        cnt_ovf_d     = cnt_ovf_q;
        per_ovf_d     = per_ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    gate_d        = gate_len;
                    acc_d         = '0;
                    per_run_d     = '0;
                    per_last_d    = '0;
                    seen_d        = 1'b0;
                    cnt_ovf_acc_d = 1'b0;
                    per_ovf_acc_d = 1'b0;
                    state_d       = (gate_len != '0) ? MEASURE : DONE;
                end
            end
            MEASURE: begin
                gate_d = gate_q - 1'b1;
                if (gate_q == GATE_W'(1)) begin
                    state_d = DONE;
                end
                if (rise) begin
                    if (&acc_q) begin
                        cnt_ovf_acc_d = 1'b1;
                    end else begin
                        acc_d = acc_q + 1'b1;
                    end
                    if (seen_q) begin
                        per_last_d = per_run_q;
                    end
                    per_run_d = PER_W'(1);
                    seen_d    = 1'b1;
                end else if (seen_q) begin
                    if (&per_run_q) begin
                        per_ovf_acc_d = 1'b1;
                    end else begin
                        per_run_d = per_run_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Results load from next-state accumulators so a rise in the last MEASURE cycle is included.
        if (state_d == DONE) begin
            edge_cnt_d = acc_d;
            period_d   = per_last_d;
            cnt_ovf_d  = cnt_ovf_acc_d;
            per_ovf_d  = per_ovf_acc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gate_q        <= '0;
            acc_q         <= '0;
            per_run_q     <= '0;
            per_last_q    <= '0;
            seen_q        <= 1'b0;
            cnt_ovf_acc_q <= 1'b0;
            per_ovf_acc_q <= 1'b0;
            edge_cnt_q    <= '0;
            period_q      <= '0;
            cnt_ovf_q     <= 1'b0;
            per_ovf_q     <= 1'b0;
            sig_d_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            gate_q        <= gate_d;
            acc_q         <= acc_d;
            per_run_q     <= per_run_d;
            per_last_q    <= per_last_d;
            seen_q        <= seen_d;
            cnt_ovf_acc_q <= cnt_ovf_acc_d;
            per_ovf_acc_q <= per_ovf_acc_d;
            edge_cnt_q    <= edge_cnt_d;
            period_q      <= period_d;
            cnt_ovf_q     <= cnt_ovf_d;
            per_ovf_q     <= per_ovf_d;
            sig_d_q       <= sig_s;
        end
    end

    assign busy     = (state_q == MEASURE);
    assign valid    = (state_q == DONE);
    assign edge_cnt = edge_cnt_q;
    assign period   = period_q;
    assign cnt_ovf  = cnt_ovf_q;
    assign per_ovf  = per_ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// Testbench for freq_meter: a default-width instance and a narrow (4-bit count/period) instance
// share stimulus; both are checked against a window/edge-list reference model.
module tb_freq_meter;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        start    = 1'b0;
    logic        sig_in   = 1'b0;
    logic [15:0] gate_len = '0;

    logic        busyA, validA, cntOvfA, perOvfA;
    logic [15:0] edgeCntA;
    logic [31:0] periodA;
    logic        busyB, validB, cntOvfB, perOvfB;
    logic [3:0]  edgeCntB, periodB;

    int compared   = 0;
    int mismatched = 0;

    bit hist[$];
    int genPer  = 4;
    int genHigh = 2;
    int genBase = 0;
    bit genRand = 1'b0;

    longint holdCntA;

`ifdef FREQ_METER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    always #5 clk = ~clk;

    freq_meter dut (
        .clk(clk), .rst_n(rst_n), .start(start), .gate_len(gate_len), .sig_in(sig_in),
        .busy(busyA), .valid(validA), .edge_cnt(edgeCntA), .period(periodA),
        .cnt_ovf(cntOvfA), .per_ovf(perOvfA)
    );

    freq_meter #(.GATE_W(16), .CNT_W(4), .PER_W(4)) dutSat (
        .clk(clk), .rst_n(rst_n), .start(start), .gate_len(gate_len), .sig_in(sig_in),
        .busy(busyB), .valid(validB), .edge_cnt(edgeCntB), .period(periodB),
        .cnt_ovf(cntOvfB), .per_ovf(perOvfB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit genSig(input int c);
        if (genRand) return bit'($urandom_range(0, 1));
        if (c < genBase) return 1'b0;
        return ((c - genBase) % genPer) < genHigh;
    endfunction

    function automatic bit sAt(input int i);
        if (i < 0) return 1'b0;
        return hist[i];
    endfunction

    // Drive one cycle's inputs, record sig_in, then advance to just after the next edge.
    task automatic applyStimulus(input bit st, input logic [15:0] g);
        bit s;
        s        = genSig(hist.size());
        sig_in   = s;
        start    = st;
        gate_len = g;
        hist.push_back(s);
        @(posedge clk);
        #1;
    endtask

    // Reference: list the rises seen by the edge detector in the window, then derive results.
    task automatic computeExp(input int first, input int last, input int cw, input int pw,
                              output longint cnt, output longint per, output bit cov, output bit pov);
        longint n, lastR, prevR, maxC, maxP;
        n     = 0;
        lastR = -1;
        prevR = -1;
        pov   = 1'b0;
        maxC  = (longint'(1) << cw) - 1;
        maxP  = (longint'(1) << pw) - 1;
        for (int c = first; c <= last; c++) begin
            if (sAt(c - LAT) && !sAt(c - LAT - 1)) begin
                n++;
                if (lastR >= 0 && (c - lastR) > maxP) pov = 1'b1;
                prevR = lastR;
                lastR = c;
            end
        end
        if (lastR >= 0 && (last - lastR) >= maxP) pov = 1'b1;
        cov = (n > maxC);
        cnt = (n > maxC) ? maxC : n;
        if (n >= 2) per = ((lastR - prevR) > maxP) ? maxP : (lastR - prevR);
        else        per = 0;
    endtask

    task automatic checkResults(input int j, input int g);
        longint cnt, per;
        bit     cov, pov;
        computeExp(j + 1, j + g, 16, 32, cnt, per, cov, pov);
        holdCntA = cnt;
        checkOutput("edge_cnt", 32'(edgeCntA), 32'(cnt));
        checkOutput("period",   periodA,       32'(per));
        checkOutput("cnt_ovf",  32'(cntOvfA),  32'(cov));
        checkOutput("per_ovf",  32'(perOvfA),  32'(pov));
        computeExp(j + 1, j + g, 4, 4, cnt, per, cov, pov);
        checkOutput("sat_edge_cnt", 32'(edgeCntB), 32'(cnt));
        checkOutput("sat_period",   32'(periodB),  32'(per));
        checkOutput("sat_cnt_ovf",  32'(cntOvfB),  32'(cov));
        checkOutput("sat_per_ovf",  32'(perOvfB),  32'(pov));
    endtask

    // One measurement: start in cycle j, busy through j+g, valid exactly at j+g+1.
    task automatic runMeasure(input int g, input bit noisy);
        int j;
        j = hist.size();
        applyStimulus(1'b1, 16'(g));
        for (int c = j + 1; c <= j + g + 1; c++) begin
            checkOutput("busy",      32'(busyA),  32'(c <= j + g));
            checkOutput("valid",     32'(validA), 32'(c == j + g + 1));
            checkOutput("sat_valid", 32'(validB), 32'(c == j + g + 1));
            if (c == j + g + 1) begin
                checkResults(j, g);
                applyStimulus(noisy, 16'd7);
            end else begin
                applyStimulus(noisy ? bit'($urandom_range(0, 1)) : 1'b0,
                              16'(1 + $urandom_range(0, 9)));
            end
        end
        checkOutput("valid_after", 32'(validA),   32'd0);
        checkOutput("busy_after",  32'(busyA),    32'd0);
        checkOutput("hold_cnt",    32'(edgeCntA), 32'(holdCntA));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},     32'(busyA),    32'd0);
        checkOutput({tag, "_valid"},    32'(validA),   32'd0);
        checkOutput({tag, "_edge_cnt"}, 32'(edgeCntA), 32'd0);
        checkOutput({tag, "_period"},   periodA,       32'd0);
        checkOutput({tag, "_cnt_ovf"},  32'(cntOvfA),  32'd0);
        checkOutput({tag, "_per_ovf"},  32'(perOvfA),  32'd0);
        checkOutput({tag, "_sat_cnt"},  32'(edgeCntB), 32'd0);
        checkOutput({tag, "_sat_per"},  32'(periodB),  32'd0);
        checkOutput({tag, "_sat_ovf"},  32'({cntOvfB, perOvfB}), 32'd0);
    endtask

    // Release reset with sig_in low and restart the history so cycle 0 follows reset.
    task automatic releaseReset();
        sig_in = 1'b0;
        start  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hist.delete();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        genRand = 1'b1;
        repeat (6) applyStimulus(1'b1, 16'd5);
        checkAllZero("reset");
        releaseReset();

        genRand = 1'b0;
        genPer  = 4;
        genHigh = 2;
        genBase = 0;
        repeat (20) begin
            applyStimulus(1'b0, 16'd9);
            checkOutput("idle_no_valid", 32'(validA), 32'd0);
        end

        runMeasure(100, 1'b0);
        genPer  = 10;
        genHigh = 5;
        runMeasure(1000, 1'b0);
        runMeasure(0, 1'b0);
        runMeasure(1, 1'b0);

        // Steady high: the only rise happens well before the window.
        genPer  = 1;
        genHigh = 1;
        genBase = hist.size();
        repeat (5) applyStimulus(1'b0, 16'd0);
        runMeasure(50, 1'b0);

        // Exactly one rise inside the window.
        genPer  = 100000;
        genHigh = 100000;
        genBase = hist.size() + 10;
        runMeasure(50, 1'b0);

        genPer  = 2;
        genHigh = 1;
        genBase = 0;
        runMeasure(64, 1'b0);
        genPer  = 40;
        genHigh = 20;
        runMeasure(200, 1'b0);

        genPer  = 6;
        genHigh = 3;
        runMeasure(60, 1'b1);

        // Reset in the middle of a measurement, then a clean measurement.
        applyStimulus(1'b1, 16'd200);
        repeat (30) applyStimulus(1'b0, 16'd0);
        #2 rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        releaseReset();
        genPer  = 8;
        genHigh = 4;
        repeat (3) applyStimulus(1'b0, 16'd0);
        runMeasure(40, 1'b0);

        repeat (8) begin
            genRand = ($urandom_range(0, 3) == 0);
            genPer  = $urandom_range(2, 40);
            genHigh = $urandom_range(1, genPer - 1);
            runMeasure($urandom_range(1, 300), bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
